// File: rtl/meter_pkg.sv
// Shared types and helpers for the peak meter: scan FSM states, counter
// width sizing and the saturating magnitude used by the channel datapath.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        UPDATE
    } meter_state_e;

    localparam int SAT_W = 64;

    // Bits needed to hold every value in 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // |x| for a width-bit signed sample carried sign-extended in SAT_W bits;
    // the most-negative code saturates to the largest positive code.
    function automatic logic [SAT_W-1:0] sat_abs(input logic signed [SAT_W-1:0] x,
                                                 input int width);
        logic signed [SAT_W-1:0] lim;
        lim = SAT_W'(1) <<< (width - 1);
        if (x == -lim) begin
            return SAT_W'(lim - 64'sd1);
        end
        return x[SAT_W-1] ? SAT_W'(-x) : SAT_W'(x);
    endfunction

endpackage

// File: rtl/meter_bar_encode.sv
// Level to thermometer bar: the top segment lights at -6 dBFS and each
// lower segment lights 6 dB (one bit position) further down.
module meter_bar_encode
    import meter_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int LED_COUNT = 8
) (
    input  logic [WIDTH-2:0]     level_i,
    output logic [LED_COUNT-1:0] bar_o
);

    // level >= 2^EXP exactly when some bit at or above EXP is set.
    for (genvar k = 0; k < LED_COUNT; k++) begin : g_seg
        localparam int EXP = WIDTH - 2 - (LED_COUNT - 1 - k);
        if (EXP >= 0) begin : g_thr
            assign bar_o[k] = (level_i[WIDTH-2:EXP] != '0);
        end else begin : g_any
            assign bar_o[k] = (level_i != '0);
        end
    end

endmodule

// File: rtl/peak_meter.sv
// Multi-channel peak meter: one channel per clock through a shared
// abs/compare datapath, with peak hold, decay, clip latching and a bar view.
module peak_meter
    import meter_pkg::*;
#(
    parameter int NUM_CHANNELS     = 8,
    parameter int WIDTH            = 24,
    parameter int LED_COUNT        = 8,
    parameter int HOLD_FRAMES      = 4800,
    parameter int DECAY_FRAMES     = 48,
    parameter int DECAY_SHIFT      = 4,
    parameter int CLIP_HOLD_FRAMES = 24000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_valid,
    input  logic [NUM_CHANNELS-1:0][WIDTH-1:0]  audio_in,
    input  logic                                clear,
    input  logic [$clog2(NUM_CHANNELS)-1:0]     channel_select,
    output logic [WIDTH-2:0]                    level_out,
    output logic [LED_COUNT-1:0]                bar,
    output logic [NUM_CHANNELS-1:0]             clip,
    output logic                                busy,
    output logic                                overrun
);

    localparam int MAG_W   = WIDTH - 1;
    localparam int IDX_W   = $clog2(NUM_CHANNELS);
    localparam int HOLD_W  = cnt_width(HOLD_FRAMES);
    localparam int CLIP_W  = cnt_width(CLIP_HOLD_FRAMES);
    localparam int FRAME_W = cnt_width(DECAY_FRAMES - 1);
    localparam logic [MAG_W-1:0] FULL_SCALE = '1;

    meter_state_e            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                    overrun_q, overrun_d;
    logic [MAG_W-1:0]        level_q, level_d;
    logic [LED_COUNT-1:0]    bar_q, bar_d;

    logic signed [WIDTH-1:0] frame_q    [NUM_CHANNELS];
    logic [MAG_W-1:0]        peak_q     [NUM_CHANNELS];
    logic [HOLD_W-1:0]       hold_q     [NUM_CHANNELS];
    logic [CLIP_W-1:0]       clip_cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] clip_q;

    logic                    capture, scan_en, decay_tick;
    logic [MAG_W-1:0]        mag, peak_cur, peak_d, decay_step, sel_peak;
    logic [HOLD_W-1:0]       hold_cur, hold_d;
    logic [CLIP_W-1:0]       clip_cnt_cur, clip_cnt_d;
    logic                    clip_d;
    logic [LED_COUNT-1:0]    bar_enc;

    assign decay_tick = (frame_cnt_q == FRAME_W'(DECAY_FRAMES - 1));
    assign sel_peak   = peak_q[channel_select];

    meter_bar_encode #(
        .WIDTH     (WIDTH),
        .LED_COUNT (LED_COUNT)
    ) u_bar_encode (
        .level_i (sel_peak),
        .bar_o   (bar_enc)
    );

    // clear beats everything, including a sample arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        level_d     = level_q;
        bar_d       = bar_q;
        capture     = 1'b0;
        scan_en     = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            overrun_d = 1'b0;
            level_d   = '0;
            bar_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        capture = 1'b1;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    scan_en = 1'b1;
                    if (sample_valid) overrun_d = 1'b1;
                    if (idx_q == IDX_W'(NUM_CHANNELS - 1)) state_d = UPDATE;
                    else idx_d = idx_q + 1'b1;
                end
                UPDATE: begin
                    if (sample_valid) overrun_d = 1'b1;
                    level_d     = sel_peak;
                    bar_d       = bar_enc;
                    frame_cnt_d = decay_tick ? '0 : frame_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mag          = MAG_W'(sat_abs(SAT_W'(frame_q[idx_q]), WIDTH));
        peak_cur     = peak_q[idx_q];
        hold_cur     = hold_q[idx_q];
        clip_cnt_cur = clip_cnt_q[idx_q];
        decay_step   = peak_cur >> DECAY_SHIFT;
        if (decay_step == '0 && peak_cur != '0) decay_step = MAG_W'(1);
        peak_d = peak_cur;
        hold_d = hold_cur;
        if (mag > peak_cur) begin
            peak_d = mag;
            hold_d = HOLD_W'(HOLD_FRAMES);
        end else if (hold_cur != '0) begin
            hold_d = hold_cur - 1'b1;
        end else if (decay_tick) begin
            peak_d = peak_cur - decay_step;
        end
        clip_d     = clip_q[idx_q];
        clip_cnt_d = clip_cnt_cur;
        if (mag == FULL_SCALE) begin
            clip_d     = 1'b1;
            clip_cnt_d = CLIP_W'(CLIP_HOLD_FRAMES);
        end else if (clip_cnt_cur != '0) begin
            clip_cnt_d = clip_cnt_cur - 1'b1;
            if (clip_cnt_cur == CLIP_W'(1)) clip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            level_q     <= '0;
            bar_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            level_q     <= level_d;
            bar_q       <= bar_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                peak_q[c]     <= '0;
                hold_q[c]     <= '0;
                clip_cnt_q[c] <= '0;
            end
        end else if (clear) begin
            clip_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                peak_q[c]     <= '0;
                hold_q[c]     <= '0;
                clip_cnt_q[c] <= '0;
            end
        end else if (scan_en) begin
            peak_q[idx_q]     <= peak_d;
            hold_q[idx_q]     <= hold_d;
            clip_cnt_q[idx_q] <= clip_cnt_d;
            clip_q[idx_q]     <= clip_d;
        end
    end

    // Frame snapshot only needs to be valid while a scan is running.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int c = 0; c < NUM_CHANNELS; c++) frame_q[c] <= audio_in[c];
        end
    end

    assign level_out = level_q;
    assign bar       = bar_q;
    assign clip      = clip_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_peak_meter.sv
// Scoreboard bench for peak_meter: stimulus queues hand-computed frame
// results, a monitor compares them when busy falls at the end of each scan.
module tb_peak_meter;

    localparam int NCH  = 8;
    localparam int W    = 24;
    localparam int LEDS = 8;

    typedef struct {
        logic [W-2:0]  level;
        logic [LEDS-1:0] bar;
        logic [NCH-1:0]  clip;
        logic          ovr;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sample_valid = 1'b0;
    logic                  clear = 1'b0;
    logic [NCH-1:0][W-1:0] audio_in = '0;
    logic [2:0]            channel_select = '0;
    logic [W-2:0]          level_out;
    logic [LEDS-1:0]       bar;
    logic [NCH-1:0]        clip;
    logic                  busy;
    logic                  overrun;

    int   totalChecks = 0;
    int   badChecks   = 0;
    exp_t sbQ[$];
    logic clearAtEdge = 1'b0;
    logic busyPrev    = 1'b0;
    int   busyLen     = 0;

    logic [W-2:0]    t2Level [7] = '{23'h400000, 23'h400000, 23'h400000, 23'h200000,
                                     23'h100000, 23'h080000, 23'h040000};
    logic [LEDS-1:0] t2Bar   [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F};
    logic [W-2:0]    t3Level [4] = '{23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h400000};
    logic [NCH-1:0]  t3Clip  [4] = '{8'h08, 8'h08, 8'h08, 8'h00};
    logic [W-2:0]    t6Level [4] = '{23'h000001, 23'h000001, 23'h000001, 23'h000000};

    peak_meter #(
        .NUM_CHANNELS     (NCH),
        .WIDTH            (W),
        .LED_COUNT        (LEDS),
        .HOLD_FRAMES      (2),
        .DECAY_FRAMES     (1),
        .DECAY_SHIFT      (1),
        .CLIP_HOLD_FRAMES (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .audio_in       (audio_in),
        .clear          (clear),
        .channel_select (channel_select),
        .level_out      (level_out),
        .bar            (bar),
        .clip           (clip),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0][W-1:0] oneCh(input int ch, input logic [W-1:0] val);
        logic [NCH-1:0][W-1:0] f;
        f     = '0;
        f[ch] = val;
        return f;
    endfunction

    function automatic exp_t mkExp(input logic [W-2:0] lv, input logic [LEDS-1:0] b,
                                   input logic [NCH-1:0] c, input logic o);
        exp_t e;
        e.level = lv;
        e.bar   = b;
        e.clip  = c;
        e.ovr   = o;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        totalChecks++;
        if (act !== req) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a falling busy not caused by clear/reset is a frame result.
    always @(posedge clk) clearAtEdge <= clear;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busyPrev = 1'b0;
            busyLen  = 0;
        end else begin
            if (busy) begin
                busyLen++;
            end else if (busyPrev) begin
                if (!clearAtEdge) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("busy_len", busyLen, NCH + 1);
                        checkOutput("level_out", level_out, e.level);
                        checkOutput("bar", bar, e.bar);
                        checkOutput("clip", clip, e.clip);
                        checkOutput("overrun", overrun, e.ovr);
                    end
                end
                busyLen = 0;
            end
            busyPrev = busy;
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("frame_timeout", sbQ.size(), 0);
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0][W-1:0] frame, input logic [2:0] sel,
                                 input exp_t e, input bit extra);
        channel_select = sel;
        sbQ.push_back(e);
        @(negedge clk);
        audio_in     = frame;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        audio_in     = '0;
        if (extra) begin
            @(negedge clk);
            @(negedge clk);
            audio_in     = oneCh(0, 24'h200000);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            audio_in     = '0;
        end
        waitDrain();
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        bit sawBusy;

        #1;
        checkOutput("reset_level", level_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] full-scale positive frame, then reset mid-scan");
        applyStimulus(oneCh(0, 24'h7FFFFF), 3'd0, mkExp(23'h7FFFFF, 8'hFF, 8'h01, 1'b0), 1'b0);
        @(negedge clk);
        audio_in     = oneCh(2, 24'h123456);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midscan_rst_busy", busy, 0);
        checkOutput("midscan_rst_level", level_out, 0);
        checkOutput("midscan_rst_bar", bar, 0);
        checkOutput("midscan_rst_clip", clip, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus('0, 3'd0, mkExp(23'h0, 8'h00, 8'h00, 1'b0), 1'b0);

        $display("[TB] negative half-scale on ch0: hold then decay");
        applyStimulus(oneCh(0, 24'hC00000), 3'd0, mkExp(t2Level[0], t2Bar[0], 8'h00, 1'b0), 1'b0);
        for (int f = 1; f < 7; f++) begin
            applyStimulus('0, 3'd0, mkExp(t2Level[f], t2Bar[f], 8'h00, 1'b0), 1'b0);
        end
        pulseClear();

        $display("[TB] most-negative sample on ch3: saturation and clip hold");
        applyStimulus(oneCh(3, 24'h800000), 3'd3, mkExp(t3Level[0], 8'hFF, t3Clip[0], 1'b0), 1'b0);
        for (int f = 1; f < 4; f++) begin
            applyStimulus('0, 3'd3, mkExp(t3Level[f], 8'hFF, t3Clip[f], 1'b0), 1'b0);
        end

        $display("[TB] second strobe while busy");
        applyStimulus(oneCh(0, 24'h010000), 3'd0, mkExp(23'h010000, 8'h03, 8'h00, 1'b1), 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("dropped_sample_no_scan", busy, 0);
        pulseClear();
        checkOutput("clear_overrun", overrun, 0);
        checkOutput("clear_level", level_out, 0);
        checkOutput("clear_bar", bar, 0);
        applyStimulus('0, 3'd3, mkExp(23'h0, 8'h00, 8'h00, 1'b0), 1'b0);

        $display("[TB] clear together with sample_valid");
        @(negedge clk);
        audio_in     = oneCh(0, 24'h7FFFFF);
        sample_valid = 1'b1;
        clear        = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        audio_in     = '0;
        sawBusy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy) sawBusy = 1'b1;
            @(negedge clk);
        end
        checkOutput("clear_wins_no_scan", sawBusy, 0);
        checkOutput("clear_wins_clip", clip, 0);
        checkOutput("clear_wins_overrun", overrun, 0);
        applyStimulus('0, 3'd0, mkExp(23'h0, 8'h00, 8'h00, 1'b0), 1'b0);

        $display("[TB] peak of one decays to zero");
        applyStimulus(oneCh(0, 24'h000001), 3'd0, mkExp(t6Level[0], 8'h00, 8'h00, 1'b0), 1'b0);
        for (int f = 1; f < 4; f++) begin
            applyStimulus('0, 3'd0, mkExp(t6Level[f], 8'h00, 8'h00, 1'b0), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/peak_meter.md
Name: peak_meter

Overview:
- Parametrised multi-channel peak meter that replaces the single-channel, combinational LED meter with per-channel sequential metering.
- Sits beside the audio path: it samples the decoded input bus (or the post-DSP bus) on each frame strobe.
- Tracks a per-channel peak with hold and decay, and latches per-channel clip flags.
- Drives a log-scaled LED bar for one selectable channel. One channel is processed per clock to share a single abs/compare datapath.

Parameters:
- NUM_CHANNELS, 8, number of audio channels metered.
- WIDTH, 24, signed sample width.
- LED_COUNT, 8, bar segments at 6 dB per segment.
- HOLD_FRAMES, 4800, frames a new peak is held before decay starts.
- DECAY_FRAMES, 48, frames between decay steps (global tick).
- DECAY_SHIFT, 4, per-step decay: peak -= peak >> DECAY_SHIFT.
- CLIP_HOLD_FRAMES, 24000, frames a clip flag stays set after the last clipped sample.

Ports:
- clk  in  1  meter clock, at least NUM_CHANNELS+2 cycles per frame.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle frame strobe; audio_in is valid this cycle.
- audio_in  in  NUM_CHANNELS x WIDTH signed  frame samples.
- clear  in  1  synchronous clear of all peaks, holds and clips.
- channel_select  in  $clog2(NUM_CHANNELS)  channel shown on level_out/bar.
- level_out  out  WIDTH-1  peak magnitude of the selected channel.
- bar  out  LED_COUNT  thermometer bar for the selected channel.
- clip  out  NUM_CHANNELS  per-channel clip indicators.
- busy  out  1  scan in progress.
- overrun  out  1  sticky; sample_valid arrived while busy.

Behaviour:
- Reset (async, any time, including mid-scan): FSM goes to IDLE. All peaks, hold counters, clip counters, the frame counter, level_out, bar, clip, busy and overrun are 0.
- FSM IDLE:
  - On sample_valid: capture audio_in into a frame register, go to SCAN with index 0, busy=1 from the next cycle.
- FSM SCAN:
  - Processes channel `idx` each cycle.
  - After idx = NUM_CHANNELS-1, goes to UPDATE.
- FSM UPDATE (one cycle):
  - Latch level_out and bar from the selected channel's peak.
  - Advance the frame counter.
  - Return to IDLE; busy=0.
- Timing: sample_valid at cycle t -> busy high t+1..t+NUM_CHANNELS+1 -> level_out/bar valid from t+NUM_CHANNELS+2.
- channel_select changes take effect only at the next UPDATE.
- Magnitude: abs = |x|. The most-negative value saturates to 2^(WIDTH-1)-1. Width is WIDTH-1 unsigned.
- Per-channel update, in priority order:
  - abs > peak: peak = abs, hold = HOLD_FRAMES.
  - else hold != 0: hold -= 1.
  - else if decay_tick: peak -= max(peak >> DECAY_SHIFT, 1 if peak != 0 else 0). Peak therefore always reaches 0.
- decay_tick:
  - Asserted for the whole frame in which the frame counter equals DECAY_FRAMES-1.
  - The counter wraps to 0 after that frame.
- Clip:
  - abs == 2^(WIDTH-1)-1 sets clip[ch]=1 and clip_cnt = CLIP_HOLD_FRAMES.
  - Otherwise, when clip_cnt != 0: clip_cnt -= 1, and clip[ch] clears when clip_cnt reaches 0.
- Bar: bar[k] = 1 iff level >= 2^(WIDTH-2-(LED_COUNT-1-k)). Top segment = -6 dBFS; each lower segment is 6 dB lower.
- sample_valid while busy: the sample is dropped, overrun is set, and overrun clears only on clear or reset.
- clear:
  - Zeroes peaks, holds, clips, overrun, level_out and bar.
  - Aborts any scan and returns to IDLE.
  - clear wins over a simultaneous sample_valid; that sample is dropped and overrun is not set.
- Frame counter and hold counters are wide enough for their parameter. HOLD_FRAMES=0 means decay immediately.

Decomposition:
- Package meter_pkg:
  - meter_state_e (IDLE, SCAN, UPDATE).
  - Width helper functions: clog2-based counter widths.
  - Function sat_abs(WIDTH).
- One sub-module, meter_bar_encode: combinational level -> thermometer, parametrised by WIDTH and LED_COUNT.
- Per-channel state is held in arrays inside peak_meter.

Test Plan (WIDTH=24, NUM_CHANNELS=8, LED_COUNT=8, HOLD_FRAMES=2, DECAY_FRAMES=1, DECAY_SHIFT=1, CLIP_HOLD_FRAMES=3):
- Reset mid-SCAN -> busy=0, level_out=0, bar=0, clip=0 immediately. The next frame scans normally.
- ch0 = -0x400000, select 0 -> level_out=0x400000 and bar=8'hFF at t+10.
  - Next frames all zero: the value holds for 2 frames, then steps 0x200000, 0x100000, ...
  - bar loses one segment per frame.
- ch3 = 24'h800000 -> level_out (select 3) = 0x7FFFFF, clip[3]=1.
  - Then 3 zero frames -> clip[3] still 1 after frame 2, 0 after frame 3.
- sample_valid asserted again 3 cycles after the first -> second sample ignored, overrun=1.
  - clear -> overrun=0, all peaks 0.
- clear and sample_valid in the same cycle with ch0=0x7FFFFF -> no scan, clip=0, overrun=0.
- Peak=1, no input -> decays to 0 after hold expires (step forced to 1), bar=0.
